// File: rtl/alu_simd_op_scheduler.sv
// Two-requester scheduler for a shared 20-bit SIMD ALU slice.
// Round-robin issue, kill-bit tracking of illegal ops through the ALU pipeline,
// drain-before-reconfigure of USE_SIMD, and a credit-protected response FIFO.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | arbitrate and issue ops whose USE_SIMD matches cur_simd
// DRAIN  | mode change pending; hold requesters until the ALU is empty
// SWITCH | one bubble after cur_simd is updated, then back to RUN
module alu_simd_op_scheduler #(
    parameter int LAT       = 2,
    parameter int RSP_DEPTH = 4,
    parameter int WIDTH     = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [7:0]       req_alumode,
    input  logic [17:0]      req_opmode,
    input  logic [3:0]       req_simd,
    input  logic [1:0]       req_cin,
    output logic [1:0]       alu_grant,
    output logic [3:0]       alu_alumode,
    output logic [8:0]       alu_opmode,
    output logic [1:0]       alu_use_simd,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_s,
    input  logic [1:0]       alu_carry_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_s,
    output logic [1:0]       rsp_carry
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam int CW = $clog2(RSP_DEPTH + LAT + 1) + 1;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    state_t          state, state_nx;
    logic            rr_ptr;
    logic [1:0]      cur_simd, cur_simd_nx;
    logic [1:0]      pend_simd, pend_simd_nx;

    logic            pipe_v   [LAT];
    logic            pipe_id  [LAT];
    logic            pipe_err [LAT];

    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic            credit;

    logic            win;
    logic            have_win;
    logic [1:0]      win_simd;
    logic [3:0]      win_alumode;
    logic [8:0]      win_opmode;
    logic            win_cin;
    logic            win_illegal;
    logic            issue;

    logic            fifo_id   [RSP_DEPTH];
    logic            fifo_err  [RSP_DEPTH];
    logic [WIDTH-1:0] fifo_s   [RSP_DEPTH];
    logic [1:0]      fifo_c    [RSP_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic            push, pop;

    // Occupancy of the ALU pipeline and the issue credit check.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(pipe_v[i]);
        end
        credit = (fifo_count + inflight) < CW'(RSP_DEPTH);
    end

    // Round-robin winner selection and illegal-op classification.
    always_comb begin
        have_win    = |req_valid;
        win         = (&req_valid) ? rr_ptr : req_valid[1];
        win_simd    = win ? req_simd[3:2]     : req_simd[1:0];
        win_alumode = win ? req_alumode[7:4]  : req_alumode[3:0];
        win_opmode  = win ? req_opmode[17:9]  : req_opmode[8:0];
        win_cin     = win ? req_cin[1]        : req_cin[0];
        win_illegal = (win_simd == 2'b11) || (win_alumode[3:2] == 2'b10);
    end

    // Next-state, accept and mode-change decisions.
    always_comb begin
        state_nx     = state;
        req_ready    = 2'b00;
        issue        = 1'b0;
        pend_simd_nx = pend_simd;
        cur_simd_nx  = cur_simd;
        case (state)
            ST_RUN: begin
                if (have_win) begin
                    if (win_illegal || (win_simd == cur_simd)) begin
                        if (credit) begin
                            issue     = 1'b1;
                            req_ready = win ? 2'b10 : 2'b01;
                        end
                    end else begin
                        pend_simd_nx = win_simd;
                        state_nx     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    cur_simd_nx = pend_simd;
                    state_nx    = ST_SWITCH;
                end
            end
            ST_SWITCH: state_nx = ST_RUN;
            default:   state_nx = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_RUN;
        else          state <= state_nx;
    end

    // Mode registers and round-robin pointer; pointer only moves on contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_simd  <= 2'b00;
            pend_simd <= 2'b00;
            rr_ptr    <= 1'b0;
        end else begin
            cur_simd  <= cur_simd_nx;
            pend_simd <= pend_simd_nx;
            if (issue && (&req_valid)) rr_ptr <= ~win;
        end
    end

    assign alu_use_simd = cur_simd;

    // ALU control launch; illegal ops and idle cycles leave controls held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_grant   <= 2'b00;
            alu_alumode <= 4'd0;
            alu_opmode  <= 9'd0;
            alu_cin     <= 1'b0;
        end else if (issue && !win_illegal) begin
            alu_grant   <= win ? 2'b10 : 2'b01;
            alu_alumode <= win_alumode;
            alu_opmode  <= win_opmode;
            alu_cin     <= win_cin;
        end else begin
            alu_grant   <= 2'b00;
        end
    end

    // Op tracking shift register aligned with the ALU latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_id[i]  <= 1'b0;
                pipe_err[i] <= 1'b0;
            end
        end else begin
            pipe_v[0]   <= issue;
            pipe_id[0]  <= win;
            pipe_err[0] <= win_illegal;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_id[i]  <= pipe_id[i-1];
                pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

    assign push = pipe_v[LAT-1];
    assign pop  = rsp_valid && rsp_ready;

    // Response FIFO storage and pointers; killed ops return zero data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_id[i]  <= 1'b0;
                fifo_err[i] <= 1'b0;
                fifo_s[i]   <= '0;
                fifo_c[i]   <= 2'b00;
            end
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_id[wptr]  <= pipe_id[LAT-1];
                fifo_err[wptr] <= pipe_err[LAT-1];
                fifo_s[wptr]   <= pipe_err[LAT-1] ? '0 : alu_s;
                fifo_c[wptr]   <= pipe_err[LAT-1] ? 2'b00 : alu_carry_out;
                wptr <= (wptr == PW'(RSP_DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(RSP_DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rsp_valid = (fifo_count != '0);
    assign rsp_id    = fifo_id[rptr];
    assign rsp_err   = fifo_err[rptr];
    assign rsp_s     = fifo_s[rptr];
    assign rsp_carry = fifo_c[rptr];

endmodule
